// File: rtl/compare_pkg.sv
// Shared definitions for the serial magnitude comparator: comparison codes,
// controller state encoding and the code-to-result evaluation.
package compare_pkg;

    localparam logic [2:0] COMP_EQ   = 3'b000;
    localparam logic [2:0] COMP_NE   = 3'b001;
    localparam logic [2:0] COMP_LT   = 3'b010;
    localparam logic [2:0] COMP_GE   = 3'b011;
    localparam logic [2:0] COMP_LE   = 3'b100;
    localparam logic [2:0] COMP_GT   = 3'b101;
    localparam logic [2:0] COMP_TRUE = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Maps a comparison code onto the final less/equal flags; the unused
    // code 111 yields 0.
    function automatic logic evalComp(input logic [2:0] code, input logic lt, input logic eq);
        case (code)
            COMP_EQ:   return eq;
            COMP_NE:   return !eq;
            COMP_LT:   return lt;
            COMP_GE:   return !lt;
            COMP_LE:   return lt | eq;
            COMP_GT:   return !lt & !eq;
            COMP_TRUE: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/compare_chunk.sv
// One step of the LSB-first scan: folds a CHUNK-bit slice of each operand
// into the running less/equal flags. Later (more significant) chunks that
// differ overwrite the verdict of earlier ones.
module compare_chunk
    import compare_pkg::*;
#(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_isTop,
    input  logic             i_signed,
    input  logic             i_ltIn,
    input  logic             i_eqIn,
    output logic             o_ltOut,
    output logic             o_eqOut
);

    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;

    // Flipping the sign bit on the top chunk turns a two's-complement order
    // into an unsigned one, so a single unsigned compare serves both modes.
    always_comb begin
        w_a     = i_a;
        w_b     = i_b;
        o_ltOut = i_ltIn;
        o_eqOut = i_eqIn;
        if (i_isTop && i_signed) begin
            w_a[CHUNK-1] = ~i_a[CHUNK-1];
            w_b[CHUNK-1] = ~i_b[CHUNK-1];
        end
        if (i_a != i_b) begin
            o_eqOut = 1'b0;
            o_ltOut = (w_a < w_b);
        end
    end

endmodule

// File: rtl/serial_compare.sv
// Multi-cycle magnitude comparator behind valid/ready handshakes. Operands
// are scanned LSB-first, CHUNK bits per cycle, and the result for the
// requested comparison code is held until the consumer takes it.
module serial_compare
    import compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [2:0]       comp_i,
    input  logic             signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             result_o,
    output logic             is_less_o,
    output logic             is_equal_o
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e             r_state;
    state_e             w_stateNext;
    logic [WIDTH-1:0]   r_srcA;
    logic [WIDTH-1:0]   r_srcB;
    logic [2:0]         r_comp;
    logic               r_signed;
    logic               r_lt;
    logic               r_eq;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_result;
    logic               r_isLess;
    logic               r_isEqual;
    logic               w_lastChunk;
    logic               w_ltNext;
    logic               w_eqNext;

    assign w_lastChunk = (r_cnt == CNT_W'(N - 1));

    compare_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a      (r_srcA[CHUNK-1:0]),
        .i_b      (r_srcB[CHUNK-1:0]),
        .i_isTop  (w_lastChunk),
        .i_signed (r_signed),
        .i_ltIn   (r_lt),
        .i_eqIn   (r_eq),
        .o_ltOut  (w_ltNext),
        .o_eqOut  (w_eqNext)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic and handshake outputs; only one command in flight.
    always_comb begin
        w_stateNext = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_stateNext = SCAN;
                end
            end
            SCAN: begin
                if (w_lastChunk) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Operand capture, per-cycle shift/flag update and final result latch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_srcA    <= '0;
            r_srcB    <= '0;
            r_comp    <= '0;
            r_signed  <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b0;
            r_cnt     <= '0;
            r_result  <= 1'b0;
            r_isLess  <= 1'b0;
            r_isEqual <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_srcA   <= src1_i;
                        r_srcB   <= src2_i;
                        r_comp   <= comp_i;
                        r_signed <= signed_i;
                        r_lt     <= 1'b0;
                        r_eq     <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                SCAN: begin
                    r_srcA <= r_srcA >> CHUNK;
                    r_srcB <= r_srcB >> CHUNK;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_lt   <= w_ltNext;
                    r_eq   <= w_eqNext;
                    if (w_lastChunk) begin
                        r_result  <= evalComp(r_comp, w_ltNext, w_eqNext);
                        r_isLess  <= w_ltNext;
                        r_isEqual <= w_eqNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign is_less_o  = r_isLess;
    assign is_equal_o = r_isEqual;

endmodule

// File: doc/serial_compare.md
Name: serial_compare

Overview:
- Multi-cycle magnitude comparator for the ALU/branch path.
- Scans two WIDTH-bit operands LSB-first, CHUNK bits per cycle, the opposite direction to the MSB-first combinational slice chain.
- Tracks less/equal flags, then evaluates a 3-bit comparison code.
- Sits behind a valid/ready handshake so the datapath can trade latency for area on set/branch compares.

Parameters:
WIDTH  32  operand width in bits
CHUNK  1  bits processed per SCAN cycle; must divide WIDTH; N = WIDTH/CHUNK

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
in_valid_i  input  1  operand/command valid
in_ready_o  output  1  block can accept a command (IDLE only)
src1_i  input  WIDTH  operand A
src2_i  input  WIDTH  operand B
comp_i  input  3  comparison code
signed_i  input  1  1 = two's-complement compare, 0 = unsigned
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
result_o  output  1  comparison outcome per comp_i
is_less_o  output  1  A < B under signed_i
is_equal_o  output  1  A == B

Behaviour:
- Reset, asynchronous while rst_i=0:
  - state=IDLE; in_ready_o=1.
  - out_valid_o, result_o, is_less_o, is_equal_o = 0.
  - Shift registers, flags and counter cleared.
  - Reset mid-SCAN or mid-DONE aborts the transaction; nothing is emitted.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: in_ready_o=1. On in_valid_i at the edge, latch src1_i, src2_i, comp_i, signed_i; set lt=0, eq=1, cnt=0; go to SCAN.
  - SCAN: in_ready_o=0. Each edge consumes the low CHUNK bits a,b of the shift registers, shifts both right by CHUNK, and increments cnt.
    - If a!=b: eq=0 and lt=(a<b) unsigned. On the top chunk (cnt==N-1) with signed_i=1, the chunk MSB is inverted before the compare.
    - If a==b: lt and eq are held.
    - At cnt==N-1, the final flags and the result are registered and the FSM goes to DONE.
  - DONE: out_valid_o=1; result_o, is_less_o, is_equal_o held stable. When out_ready_i=1 at an edge, go to IDLE and drop out_valid_o.
- Latency:
  - Accept at edge k gives out_valid_o=1 from edge k+N; 32 cycles at the defaults.
  - No overlap: the next command is accepted no earlier than the edge after the result handshake.
- comp_i encoding and result_o:
  - 000 EQ = eq
  - 001 NE = !eq
  - 010 LT = lt
  - 011 GE = !lt
  - 100 LE = lt|eq
  - 101 GT = !lt&!eq
  - 110 TRUE = 1
  - 111 reserved = 0
- Boundaries:
  - in_valid_i outside IDLE is ignored; the caller keeps it asserted.
  - out_ready_i outside DONE is ignored.
  - Operand inputs may change freely after acceptance.
  - src1==src2 gives lt=0, eq=1.
  - Most-negative vs most-positive is correct in signed mode only via the MSB inversion.

Decomposition:
- Shared package compare_pkg (include header in the Verilog-2001 flow) holds:
  - the comp_i code constants COMP_EQ .. COMP_TRUE;
  - the state encodings IDLE/SCAN/DONE.
- One combinational sub-module, compare_chunk:
  - Inputs: CHUNK-bit a and b, is_top, signed, lt_in, eq_in.
  - Outputs: lt_out, eq_out.
  - Instantiated once in the SCAN datapath.

Test Plan:
- Unsigned LT: src1=5, src2=7, comp=010, signed=0 -> out_valid_o exactly 32 cycles after accept; result_o=1, is_less_o=1, is_equal_o=0.
- Sign handling: src1=32'hFFFFFFFF, src2=1, comp=010. signed=1 -> result_o=1, is_less_o=1. signed=0 -> result_o=0, is_less_o=0.
- Equality, src1=src2=32'h12345678, run once per code:
  - EQ (000) -> 1
  - NE (001) -> 0
  - LE (100) -> 1
  - GT (101) -> 0
  - GE (011) -> 1
  - code 111 -> 0
- Backpressure: out_ready_i=0 for 10 cycles in DONE -> out_valid_o and all results stable, in_ready_o=0, a new in_valid_i pulse is ignored. Raising out_ready_i -> IDLE next edge.
- Reset mid-operation: drive rst_i=0 at SCAN cycle 10 -> all outputs 0 immediately and in_ready_o=1. A following compare of 3 vs 3 with GE returns result_o=1.
- CHUNK=4: src1=32'h80000000, src2=32'h7FFFFFFF, signed=1, comp=010 -> result_o=1, latency 8 cycles. Same operands unsigned -> result_o=0.
